// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game state encoding, key codes and score helper
// Used by the player game sequencer and its key decoder.
package game_pkg;

  typedef enum logic [1:0] {
    TITLE = 2'd0,
    PLAY  = 2'd1,
    HIT   = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_ENTER = 8'h28;

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/player_game_ctrl_key_scan.sv
// rtl/player_game_ctrl_key_scan.sv - combinational decode of four USB HID key slots
// A key counts as pressed when any slot holds its code.
module key_scan
  import game_pkg::*;
(
  input  logic [31:0] keycode,
  output logic        left,
  output logic        right,
  output logic        up,
  output logic        down,
  output logic        enter
);

  always_comb begin
    left  = 1'b0;
    right = 1'b0;
    up    = 1'b0;
    down  = 1'b0;
    enter = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (keycode[i*8 +: 8] == KEY_A)     left  = 1'b1;
      if (keycode[i*8 +: 8] == KEY_D)     right = 1'b1;
      if (keycode[i*8 +: 8] == KEY_W)     up    = 1'b1;
      if (keycode[i*8 +: 8] == KEY_S)     down  = 1'b1;
      if (keycode[i*8 +: 8] == KEY_ENTER) enter = 1'b1;
    end
  end

endmodule

// File: rtl/player_game_ctrl.sv
// rtl/player_game_ctrl.sv - frame-rate game FSM driving player sprite motion
// Produces registered step commands, lives, blink and survival score.
module player_game_ctrl
  import game_pkg::*;
#(
  parameter logic [9:0] STEP          = 10'd2,
  parameter logic [1:0] LIVES_INIT    = 2'd3,
  parameter logic [7:0] INVULN_FRAMES = 8'd120,
  parameter int         BLINK_BIT     = 3
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [31:0] keycode,
  input  logic        collide,
  output logic [9:0]  motion_x,
  output logic [9:0]  motion_y,
  output logic        recenter,
  output logic [1:0]  state,
  output logic [1:0]  lives,
  output logic        blink_hide,
  output logic [15:0] score
);

  logic left, right, up, down, enter_now;
  logic enter_q, start_edge;
  logic [7:0] inv_cnt;
  game_state_t state_q, state_d;
  logic [1:0]  lives_d;
  logic [15:0] score_d;
  logic [7:0]  inv_d;
  logic        recenter_d, blink_d;
  logic [9:0]  step_x, step_y, motion_x_d, motion_y_d;

  key_scan u_key_scan (
    .keycode (keycode),
    .left    (left),
    .right   (right),
    .up      (up),
    .down    (down),
    .enter   (enter_now)
  );

  assign start_edge = enter_now & ~enter_q;
  assign state      = state_q;

  // Opposite keys cancel; the negative step is the two's complement of STEP.
  assign step_x = (right & ~left) ? STEP : (left & ~right) ? (10'd0 - STEP) : 10'd0;
  assign step_y = (down & ~up)    ? STEP : (up & ~down)    ? (10'd0 - STEP) : 10'd0;

  always_comb begin
    state_d    = state_q;
    lives_d    = lives;
    score_d    = score;
    inv_d      = inv_cnt;
    recenter_d = 1'b0;
    blink_d    = 1'b0;
    motion_x_d = 10'd0;
    motion_y_d = 10'd0;
    case (state_q)
      TITLE: begin
        if (start_edge) begin
          state_d    = PLAY;
          lives_d    = LIVES_INIT;
          score_d    = 16'd0;
          recenter_d = 1'b1;
        end
      end
      PLAY: begin
        score_d = sat_inc(score);
        if (collide) begin
          if (lives == 2'd1) begin
            state_d = OVER;
            lives_d = 2'd0;
          end else begin
            state_d    = HIT;
            lives_d    = lives - 2'd1;
            inv_d      = INVULN_FRAMES - 8'd1;
            recenter_d = 1'b1;
          end
        end
      end
      HIT: begin
        score_d = sat_inc(score);
        if (inv_cnt == 8'd0) begin
          state_d = PLAY;
        end else begin
          inv_d   = inv_cnt - 8'd1;
          blink_d = inv_cnt[BLINK_BIT];
        end
      end
      OVER: begin
        if (start_edge) state_d = TITLE;
      end
      default: state_d = TITLE;
    endcase
    // Motion follows the state the sprite will be in, and is muted on a recenter frame.
    if ((state_d == PLAY || state_d == HIT) && !recenter_d) begin
      motion_x_d = step_x;
      motion_y_d = step_y;
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= TITLE;
      lives      <= LIVES_INIT;
      motion_x   <= 10'd0;
      motion_y   <= 10'd0;
      recenter   <= 1'b0;
      blink_hide <= 1'b0;
      score      <= 16'd0;
      inv_cnt    <= 8'd0;
      enter_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      lives      <= lives_d;
      motion_x   <= motion_x_d;
      motion_y   <= motion_y_d;
      recenter   <= recenter_d;
      blink_hide <= blink_d;
      score      <= score_d;
      inv_cnt    <= inv_d;
      enter_q    <= enter_now;
    end
  end

endmodule
